// File: rtl/aes_subbytes_seq.sv
// Iterative AES SubBytes: NUM_SBOX bytes per cycle through combinational S-boxes.
// Optional build macro SUBBYTES_ZEROIZE_EN clears the data register after use and masks out_block.

module cmt_sbox (
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Multiplicative inverse as x^254 by an addition chain; zero maps to zero.
  always_comb begin
    x2   = gf_mul(plain, plain);
    x3   = gf_mul(x2, plain);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
  end

  assign subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_subbytes_seq #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int STEPS = 16 / NUM_SBOX;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
      $error("aes_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  data_q;
  logic [127:0]  data_next;
  logic [7:0]    sbox_in  [NUM_SBOX];
  logic [7:0]    sbox_out [NUM_SBOX];

  function automatic logic [6:0] byte_msb(input int idx);
    return 7'(127 - 8 * idx);
  endfunction

  always_comb begin
    for (int j = 0; j < NUM_SBOX; j++) begin
      sbox_in[j] = data_q[byte_msb(int'(cnt) * NUM_SBOX + j) -: 8];
    end
  end

  always_comb begin
    data_next = data_q;
    for (int j = 0; j < NUM_SBOX; j++) begin
      data_next[byte_msb(int'(cnt) * NUM_SBOX + j) -: 8] = sbox_out[j];
    end
  end

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    cmt_sbox u_sbox (
      .plain(sbox_in[j]),
      .subst(sbox_out[j])
    );
  end

  // The counter returns to 0 after its last step so the byte window stays in range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SUBBYTES_ZEROIZE_EN
      data_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_block;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          data_q <= data_next;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef SUBBYTES_ZEROIZE_EN
            data_q    <= '0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUBBYTES_ZEROIZE_EN
  assign out_block = out_valid ? data_q : '0;
`else
  assign out_block = data_q;
`endif

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Scoreboard bench for aes_subbytes_seq, sweeping NUM_SBOX over 1, 2, 4, 8 and 16 in parallel lanes.
// Expected values come from constants or a brute-force GF(2^8) SubBytes model.

module tb_aes_subbytes_seq;

  logic clk;
  logic reset_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  logic [7:0] sbox_tab [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul_ref(input logic [7:0] x, input logic [7:0] y);
    int a, b, p;
    a = int'(x);
    b = int'(y);
    p = 0;
    while (b != 0) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
      b = b >> 1;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] affine_ref(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  // S-box table by exhaustive inverse search, then the affine map.
  initial begin
    for (int v = 0; v < 256; v++) begin
      int inv;
      inv = 0;
      for (int c = 1; c < 256; c++)
        if (gmul_ref(8'(v), 8'(c)) == 8'd1) inv = c;
      sbox_tab[v] = affine_ref(8'(inv));
    end
  end

  function automatic logic [127:0] subbytes_ref(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127 - 8 * i -: 8] = sbox_tab[blk[127 - 8 * i -: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("[TB] FAIL %s", name);
  endtask

  for (genvar g = 0; g < 5; g++) begin : lane
    localparam int N = 1 << g;
    localparam int L = 16 / N;

    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [127:0] exp_q [$];
    int           lat_q [$];
    logic         prev_valid = 1'b0;
    bit           rand_ready = 1'b0;
    bit           done = 1'b0;
    int           acc_cyc;

    aes_subbytes_seq #(.NUM_SBOX(N)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .abort    (abort),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_block (in_block),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_block(out_block),
      .busy     (busy)
    );

    // Called one time unit after a rising edge; returns likewise, after the accept edge.
    task automatic apply_stimulus(input logic [127:0] blk, input logic [127:0] exp);
      bit got;
      got = 1'b0;
      in_block = blk;
      in_valid = 1'b1;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
      end
      if (!got) begin
        fail_now($sformatf("N%0d accept timeout", N));
        in_valid = 1'b0;
      end else begin
        exp_q.push_back(exp);
        lat_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_block = {$urandom, $urandom, $urandom, $urandom};
      end
    endtask

    task automatic check_output();
      if (exp_q.size() == 0) fail_now($sformatf("N%0d unexpected output %h", N, out_block));
      else check($sformatf("N%0d out_block", N), out_block, exp_q.pop_front());
    endtask

    task automatic drain();
      for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) fail_now($sformatf("N%0d drain timeout, %0d pending", N, exp_q.size()));
      @(posedge clk);
      #1;
    endtask

    always @(negedge clk) begin
      if (reset_n) begin
        if (out_valid && !prev_valid) begin
          if (lat_q.size() == 0) begin
            fail_now($sformatf("N%0d out_valid rose with no accept", N));
          end else begin
            acc_cyc = lat_q.pop_front();
            check($sformatf("N%0d latency", N), 128'(cyc - acc_cyc), 128'(L));
          end
        end
        if (out_valid && out_ready) check_output();
      end
      prev_valid <= out_valid;
    end

    initial begin
      logic [127:0] blk;
      logic [127:0] e;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_block  = '0;
      out_ready = 1'b0;

      @(negedge clk);
      check($sformatf("N%0d reset flags {ov,ir,busy}", N), 128'({out_valid, in_ready, busy}), 128'(3'b010));
      check($sformatf("N%0d reset out_block", N), out_block, 128'h0);
      wait (reset_n === 1'b1);
      @(posedge clk);
      #1;

      out_ready = 1'b1;
      apply_stimulus(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
      apply_stimulus(128'h0, {16{8'h63}});
      apply_stimulus({16{8'hff}}, {16{8'h16}});
      drain();

      // Backpressure: output must hold for ten cycles with in_ready low.
      out_ready = 1'b0;
      blk = {$urandom, $urandom, $urandom, $urandom};
      e = subbytes_ref(blk);
      apply_stimulus(blk, e);
      for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        check($sformatf("N%0d stall out_block", N), out_block, e);
        check($sformatf("N%0d stall {ov,ir,busy}", N), 128'({out_valid, in_ready, busy}), 128'(3'b101));
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("N%0d after release {ov,ir,busy}", N), 128'({out_valid, in_ready, busy}), 128'(3'b010));
      drain();

      // Abort in the second cycle after accept drops the block.
      out_ready = 1'b0;
      blk = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(blk, subbytes_ref(blk));
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      if (lat_q.size() > 0) void'(lat_q.pop_back());
      @(negedge clk);
      check($sformatf("N%0d abort {ov,ir,busy}", N), 128'({out_valid, in_ready, busy}), 128'(3'b010));
`ifdef SUBBYTES_ZEROIZE_EN
      check($sformatf("N%0d abort zeroized", N), out_block, 128'h0);
`endif
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      blk = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(blk, subbytes_ref(blk));
      drain();

      // Random states with random idle gaps and random downstream stalls.
      rand_ready = 1'b1;
      fork
        begin
          while (rand_ready) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join_none
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        blk = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(blk, subbytes_ref(blk));
      end
      drain();
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      done = 1'b1;
    end
  end

  initial begin
    bit all_done;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    all_done = 1'b0;
    for (int t = 0; t < 95000 && !all_done; t++) begin
      @(posedge clk);
      all_done = lane[0].done && lane[1].done && lane[2].done && lane[3].done && lane[4].done;
    end
    if (!all_done) fail_now("run timeout before all lanes finished");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
